// File: rtl/poly_note_player.sv
// Multi-voice DDS note player. Each voice has its own phase accumulator,
// beat counter and IDLE/PLAY FSM. The voice outputs are summed and scaled
// into one signed sample stream. Deasserting play_enable freezes every
// voice and the sample pipeline in place.
module poly_note_player #(
  parameter int NUM_VOICES = 2,
  parameter int DUR_W      = 6,
  parameter int PHASE_W    = 22,
  parameter int SAMPLE_W   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play_enable,
  input  logic                          beat,
  input  logic                          sampling_pulse,
  input  logic [NUM_VOICES-1:0]         load_new_note,
  input  logic [NUM_VOICES*PHASE_W-1:0] k_to_load,
  input  logic [NUM_VOICES*DUR_W-1:0]   duration_to_load,
  input  logic [NUM_VOICES-1:0]         wave_to_load,
  output logic [NUM_VOICES-1:0]         note_done,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic [SAMPLE_W-1:0]           sample,
  output logic                          sample_ready
);

  localparam int MIX_SH = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 0;
  localparam int SUM_W  = SAMPLE_W + MIX_SH;

  // Half-scale constants for the waveform generators.
  localparam logic [SAMPLE_W-1:0] H_VAL   = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] SQ_HIGH = {1'b0, {(SAMPLE_W-1){1'b1}}};

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } voice_state_t;

  voice_state_t                  state_r      [NUM_VOICES];
  voice_state_t                  state_next_s [NUM_VOICES];
  logic [PHASE_W-1:0]            k_r          [NUM_VOICES];
  logic [PHASE_W-1:0]            phase_r      [NUM_VOICES];
  logic [DUR_W-1:0]              dur_r        [NUM_VOICES];
  logic [DUR_W-1:0]              cnt_r        [NUM_VOICES];
  logic [DUR_W-1:0]              dur_in_s     [NUM_VOICES];
  logic [NUM_VOICES-1:0]         wave_r;
  logic [NUM_VOICES-1:0]         load_s;
  logic [NUM_VOICES-1:0]         beat_s;
  logic [NUM_VOICES-1:0]         done_next_s;
  logic                          sample_stage_r;
  logic signed [SAMPLE_W-1:0]    voice_val_s  [NUM_VOICES];
  logic signed [SUM_W-1:0]       sum_s;
  logic [SAMPLE_W-1:0]           mix_s;

  // Waveform of one voice from the top SAMPLE_W bits of its phase.
  function automatic logic signed [SAMPLE_W-1:0] wave_value(
    input logic [PHASE_W-1:0] ph,
    input logic               tri_sel
  );
    logic [SAMPLE_W-1:0] u;
    logic [SAMPLE_W-1:0] dbl;
    logic [SAMPLE_W-1:0] t;
    u   = ph[PHASE_W-1 -: SAMPLE_W];
    dbl = {u[SAMPLE_W-2:0], 1'b0};
    if (tri_sel) begin
      t = u[SAMPLE_W-1] ? ~dbl : dbl;
      wave_value = t ^ H_VAL;
    end else begin
      wave_value = u[SAMPLE_W-1] ? H_VAL : SQ_HIGH;
    end
  endfunction

  // Per-voice next-state logic: a load beats a coinciding beat, and the
  // beat that reaches the latched duration ends the note.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      load_s[v]       = play_enable & load_new_note[v];
      beat_s[v]       = play_enable & beat & ~load_new_note[v];
      dur_in_s[v]     = duration_to_load[v*DUR_W +: DUR_W];
      state_next_s[v] = state_r[v];
      done_next_s[v]  = 1'b0;
      case (state_r[v])
        IDLE: begin
          if (load_s[v]) begin
            if (dur_in_s[v] == {DUR_W{1'b0}}) begin
              state_next_s[v] = IDLE;
              done_next_s[v]  = 1'b1;
            end else begin
              state_next_s[v] = PLAY;
            end
          end else begin
            state_next_s[v] = IDLE;
          end
        end
        PLAY: begin
          if (load_s[v]) begin
            if (dur_in_s[v] == {DUR_W{1'b0}}) begin
              state_next_s[v] = IDLE;
              done_next_s[v]  = 1'b1;
            end else begin
              state_next_s[v] = PLAY;
            end
          end else if (beat_s[v] && ((cnt_r[v] + DUR_W'(1'b1)) == dur_r[v])) begin
            state_next_s[v] = IDLE;
            done_next_s[v]  = 1'b1;
          end else begin
            state_next_s[v] = PLAY;
          end
        end
        default: begin
          state_next_s[v] = IDLE;
        end
      endcase
    end
  end

  // Per-voice contribution and the scaled mix of all voices.
  always_comb begin
    sum_s = {SUM_W{1'b0}};
    for (int v = 0; v < NUM_VOICES; v++) begin
      if ((state_r[v] == PLAY) && (k_r[v] != {PHASE_W{1'b0}})) begin
        voice_val_s[v] = wave_value(phase_r[v], wave_r[v]);
      end else begin
        voice_val_s[v] = {SAMPLE_W{1'b0}};
      end
      sum_s = sum_s + SUM_W'(voice_val_s[v]);
    end
    mix_s = SAMPLE_W'(sum_s >>> MIX_SH);
  end

  // Voice registers, phase accumulators and the two-stage sample pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_r[v] <= IDLE;
        k_r[v]     <= {PHASE_W{1'b0}};
        phase_r[v] <= {PHASE_W{1'b0}};
        dur_r[v]   <= {DUR_W{1'b0}};
        cnt_r[v]   <= {DUR_W{1'b0}};
      end
      wave_r         <= {NUM_VOICES{1'b0}};
      note_done      <= {NUM_VOICES{1'b0}};
      voice_active   <= {NUM_VOICES{1'b0}};
      sample         <= {SAMPLE_W{1'b0}};
      sample_ready   <= 1'b0;
      sample_stage_r <= 1'b0;
    end else if (play_enable) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        state_r[v]      <= state_next_s[v];
        voice_active[v] <= (state_next_s[v] == PLAY);
        if (load_s[v]) begin
          k_r[v]     <= k_to_load[v*PHASE_W +: PHASE_W];
          dur_r[v]   <= dur_in_s[v];
          wave_r[v]  <= wave_to_load[v];
          phase_r[v] <= {PHASE_W{1'b0}};
          cnt_r[v]   <= {DUR_W{1'b0}};
        end else if (state_r[v] == PLAY) begin
          if (beat_s[v]) begin
            cnt_r[v] <= cnt_r[v] + DUR_W'(1'b1);
          end
          if (sampling_pulse) begin
            phase_r[v] <= phase_r[v] + k_r[v];
          end
        end
      end
      note_done      <= done_next_s;
      sample_stage_r <= sampling_pulse;
      if (sample_stage_r) begin
        sample       <= mix_s;
        sample_ready <= 1'b1;
      end else begin
        sample_ready <= 1'b0;
      end
    end else begin
      note_done    <= {NUM_VOICES{1'b0}};
      sample_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_poly_note_player.sv
// Directed bench for poly_note_player with hand-computed expected values.
module tb_poly_note_player;

  localparam int NV = 2;
  localparam int DW = 6;
  localparam int PW = 22;
  localparam int SW = 16;
  localparam logic [PW-1:0] K20 = 22'h100000;
  localparam logic [PW-1:0] K21 = 22'h200000;

  logic              clk = 1'b0;
  logic              reset;
  logic              play_enable;
  logic              beat;
  logic              sampling_pulse;
  logic [NV-1:0]     load_new_note;
  logic [NV*PW-1:0]  k_to_load;
  logic [NV*DW-1:0]  duration_to_load;
  logic [NV-1:0]     wave_to_load;
  logic [NV-1:0]     note_done;
  logic [NV-1:0]     voice_active;
  logic [SW-1:0]     sample;
  logic              sample_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  poly_note_player #(
    .NUM_VOICES(NV), .DUR_W(DW), .PHASE_W(PW), .SAMPLE_W(SW)
  ) dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .beat(beat),
    .sampling_pulse(sampling_pulse), .load_new_note(load_new_note),
    .k_to_load(k_to_load), .duration_to_load(duration_to_load),
    .wave_to_load(wave_to_load), .note_done(note_done),
    .voice_active(voice_active), .sample(sample), .sample_ready(sample_ready)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [NV-1:0] mask, input logic [NV*PW-1:0] k,
                      input logic [NV*DW-1:0] dur, input logic [NV-1:0] wv);
    load_new_note    = mask;
    k_to_load        = k;
    duration_to_load = dur;
    wave_to_load     = wv;
    step();
    load_new_note    = '0;
  endtask

  task automatic do_beat();
    beat = 1'b1;
    step();
    beat = 1'b0;
  endtask

  // One sampling pulse: ready must be low at T+1, high with the sample at T+2.
  task automatic pulse_check(input string tag, input int exp);
    sampling_pulse = 1'b1;
    step();
    sampling_pulse = 1'b0;
    check({tag, "_rdy_early"}, sample_ready, 0);
    step();
    check({tag, "_rdy"}, sample_ready, 1);
    check(tag, $signed(sample), exp);
    step();
  endtask

  initial begin
    reset = 1'b1; play_enable = 1'b1; beat = 1'b0; sampling_pulse = 1'b0;
    load_new_note = '0; k_to_load = '0; duration_to_load = '0; wave_to_load = '0;
    step(); step();
    reset = 1'b0;
    check("init_active", voice_active, 0);
    check("init_sample", $signed(sample), 0);

    // 1: reset in the middle of a note
    load(2'b01, {22'd0, K20}, {6'd0, 6'd5}, 2'b00);
    pulse_check("t1_pre", 16383);
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    check("t1_sample", $signed(sample), 0);
    check("t1_done", note_done, 0);
    check("t1_active", voice_active, 0);
    check("t1_rdy", sample_ready, 0);
    pulse_check("t1_after", 0);

    // 2: square voice0, wrap, completion timing
    load(2'b01, {22'd0, K20}, {6'd0, 6'd3}, 2'b00);
    check("t2_active", voice_active, 1);
    pulse_check("t2_s1", 16383);
    pulse_check("t2_s2", -16384);
    pulse_check("t2_s3", -16384);
    pulse_check("t2_s4", 16383);
    do_beat();
    check("t2_b1_done", note_done, 0);
    do_beat();
    check("t2_b2_done", note_done, 0);
    check("t2_b2_active", voice_active, 1);
    do_beat();
    check("t2_b3_done", note_done, 1);
    check("t2_b3_active", voice_active, 0);
    step();
    check("t2_done_clear", note_done, 0);

    // 3: voice0 triangle k=2^20 mixed with voice1 square k=2^21
    load(2'b11, {K21, K20}, {6'd10, 6'd10}, 2'b01);
    check("t3_active", voice_active, 3);
    pulse_check("t3_s1", -16384);
    pulse_check("t3_s2", 32767);
    pulse_check("t3_s3", -16385);
    pulse_check("t3_s4", -1);
    reset = 1'b1;
    step();
    reset = 1'b0;

    // 4: pause freezes everything
    load(2'b01, {22'd0, K20}, {6'd0, 6'd3}, 2'b00);
    do_beat();
    pulse_check("t4_pre", 16383);
    play_enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      beat           = ((i % 6) == 1);
      sampling_pulse = ((i % 5) == 2);
      step();
      check("t4_p_rdy", sample_ready, 0);
      check("t4_p_done", note_done, 0);
      check("t4_p_sample", $signed(sample), 16383);
      check("t4_p_active", voice_active, 1);
    end
    beat = 1'b0; sampling_pulse = 1'b0;
    play_enable = 1'b1;
    pulse_check("t4_resume", -16384);
    do_beat();
    check("t4_b2_done", note_done, 0);
    do_beat();
    check("t4_b3_done", note_done, 1);
    check("t4_b3_active", voice_active, 0);

    // 5: retrigger voice1 on its final beat
    load(2'b10, {K21, 22'd0}, {6'd2, 6'd0}, 2'b00);
    pulse_check("t5_pre", -16384);
    do_beat();
    beat = 1'b1;
    load(2'b10, {K21, 22'd0}, {6'd2, 6'd0}, 2'b00);
    beat = 1'b0;
    check("t5_rt_done", note_done, 0);
    check("t5_rt_active", voice_active, 2);
    step();
    check("t5_rt_done2", note_done, 0);
    pulse_check("t5_restart", -16384);
    do_beat();
    check("t5_b1_done", note_done, 0);
    do_beat();
    check("t5_b2_done", note_done, 2);
    check("t5_b2_active", voice_active, 0);

    // 6: zero duration, then a rest note
    load(2'b01, {22'd0, K20}, {6'd0, 6'd0}, 2'b00);
    check("t6_d0_done", note_done, 1);
    check("t6_d0_active", voice_active, 0);
    step();
    check("t6_d0_clear", note_done, 0);
    pulse_check("t6_d0_sample", 0);
    load(2'b01, {22'd0, 22'd0}, {6'd0, 6'd2}, 2'b00);
    check("t6_rest_active", voice_active, 1);
    pulse_check("t6_rest_sample", 0);
    do_beat();
    check("t6_rest_b1", note_done, 0);
    do_beat();
    check("t6_rest_b2", note_done, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
